ccc_reconfig_ctrl: RTL and testbench
====================================

CCC_RECONFIG_CTRL -- requirements
Module: ccc_reconfig_ctrl

Interface
REQ-001 SHALL have parameter ARST_CYCLES, default 16, giving the width in clocks of the PLL reset pulse.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, giving the consecutive synced-lock clocks required to qualify lock.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the bound in clocks on the busy wait and on the lock wait.
REQ-004 PCLK  in  1  single clock; all logic rising-edge.
REQ-005 PRESET_N  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-008 req_write  in  1  1 = write, 0 = read.
REQ-009 req_relock  in  1  after a write, reset the PLL and wait for qualified lock.
REQ-010 req_addr  in  6  CCC configuration register address.
REQ-011 req_wdata  in  8  write data.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  8  read data; 0 for writes.
REQ-014 rsp_err  out  1  busy or lock timeout; valid with rsp_valid.
REQ-015 ccc_psel, ccc_penable, ccc_pwrite  out  1 each  APB control to the CCC.
REQ-016 ccc_paddr  out  6  APB address.
REQ-017 ccc_pwdata  out  8  APB write data.
REQ-018 ccc_prdata  in  8  APB read data.
REQ-019 ccc_busy  in  1  CCC configuration busy, synchronous to PCLK.
REQ-020 ccc_lock  in  1  raw PLL lock, asynchronous.
REQ-021 ccc_pll_arst_n  out  1  PLL reset, active-low.
REQ-022 locked  out  1  qualified lock status.

Function
REQ-023 ccc_lock SHALL pass through a 2-flop synchronizer, giving lock_s; no other logic uses raw ccc_lock.
REQ-024 The stable counter SHALL increment while lock_s=1, saturate at LOCK_STABLE_CYCLES, and clear when lock_s=0 or ccc_pll_arst_n=0.
REQ-025 locked SHALL be 1 exactly when the stable counter equals LOCK_STABLE_CYCLES.
REQ-026 The FSM SHALL have states IDLE, WAIT_BUSY, SETUP, ACCESS, ARST, WAIT_LOCK and RESP.
REQ-027 req_ready SHALL equal (state==IDLE); on handshake the FSM SHALL capture write, relock, addr and wdata and enter WAIT_BUSY.
REQ-028 In WAIT_BUSY, ccc_busy=0 SHALL go to SETUP; busy held high for TIMEOUT_CYCLES clocks SHALL go to RESP with rsp_err=1 and no APB access.
REQ-029 SETUP SHALL drive psel=1, penable=0; ACCESS SHALL drive psel=1, penable=1; each lasts one cycle (no wait states).
REQ-030 paddr, pwrite and pwdata SHALL be stable from SETUP through ACCESS; all APB outputs SHALL be 0 in every other state.
REQ-031 For reads, rsp_rdata SHALL capture ccc_prdata on the clock edge that ends ACCESS.
REQ-032 After ACCESS, a write with relock=1 SHALL go to ARST; every other request SHALL go to RESP.
REQ-033 ARST SHALL hold ccc_pll_arst_n=0 for exactly ARST_CYCLES clocks, then go to WAIT_LOCK.
REQ-034 WAIT_LOCK SHALL go to RESP with rsp_err=0 when locked=1, or with rsp_err=1 after TIMEOUT_CYCLES clocks without locked.
REQ-035 RESP SHALL assert rsp_valid for one cycle (no backpressure), then return to IDLE.
REQ-036 Latency with busy=0 and no relock: handshake in cycle N, then rsp_valid in cycle N+4.
REQ-037 If lock drops during WAIT_LOCK, the stable count SHALL restart; the timeout count SHALL NOT restart.

Reset
REQ-038 While PRESET_N=0: state=IDLE, all counters 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, APB outputs 0, ccc_pll_arst_n=1, locked=0, synchronizer flops 0.
REQ-039 Reset asserted mid-operation SHALL abort immediately with no rsp_valid, and SHALL release the PLL reset (ccc_pll_arst_n=1).

Verification
REQ-040 Read addr 0x15, busy=0, prdata=0xA7 -> SETUP/ACCESS on cycles N+2/N+3, rsp_valid at N+4, rsp_rdata=0xA7, rsp_err=0.
REQ-041 Write 0x2C to addr 0x03 with relock=1; lock returns 40 clocks after release (LOCK_STABLE_CYCLES=8 for this test) -> arst_n low exactly 16 clocks, rsp_valid with rsp_err=0, locked=1.
REQ-042 Busy held high for TIMEOUT_CYCLES=100 -> no psel, rsp_valid at timeout with rsp_err=1.
REQ-043 Relock write with lock never returning (TIMEOUT_CYCLES=200) -> rsp_err=1, locked=0.
REQ-044 Lock glitches low for 1 clock at stable count 5 of 8 -> count restarts, locked delayed accordingly, no timeout-counter reset.
REQ-045 PRESET_N asserted during ARST -> arst_n=1 immediately, no rsp_valid; after release req_ready=1 and the next read completes normally.

Source files
------------

// File: rtl/ccc_reconfig_ctrl.sv
// CCC reconfiguration controller: APB access to the CCC, with an optional PLL
// reset and a wait for qualified lock after a write.
module ccc_reconfig_ctrl #(
  parameter int unsigned ARST_CYCLES        = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned TIMEOUT_CYCLES     = 65535
) (
  input  logic       PCLK,
  input  logic       PRESET_N,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_relock,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       ccc_psel,
  output logic       ccc_penable,
  output logic       ccc_pwrite,
  output logic [5:0] ccc_paddr,
  output logic [7:0] ccc_pwdata,
  input  logic [7:0] ccc_prdata,
  input  logic       ccc_busy,
  input  logic       ccc_lock,
  output logic       ccc_pll_arst_n,
  output logic       locked
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > ARST_CYCLES) ? TIMEOUT_CYCLES : ARST_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned SW      = $clog2(LOCK_STABLE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_BUSY, SETUP, ACCESS, ARST, WAIT_LOCK, RESP
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [SW-1:0]  stable_cnt;
  logic           lock_m, lock_s;
  logic           cap_write, cap_relock;
  logic [5:0]     cap_addr;
  logic [7:0]     cap_wdata;

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= ccc_lock;
      lock_s <= lock_m;
    end
  end

  // Lock qualification: consecutive synced-lock clocks, cleared while the PLL is held in reset.
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      stable_cnt <= '0;
    end else if (!lock_s || !ccc_pll_arst_n) begin
      stable_cnt <= '0;
    end else if (stable_cnt != SW'(LOCK_STABLE_CYCLES)) begin
      stable_cnt <= stable_cnt + SW'(1);
    end
  end

  assign locked    = (stable_cnt == SW'(LOCK_STABLE_CYCLES));
  assign req_ready = (state == IDLE);

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state          <= IDLE;
      cnt            <= '0;
      cap_write      <= 1'b0;
      cap_relock     <= 1'b0;
      cap_addr       <= '0;
      cap_wdata      <= '0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      ccc_psel       <= 1'b0;
      ccc_penable    <= 1'b0;
      ccc_pwrite     <= 1'b0;
      ccc_paddr      <= '0;
      ccc_pwdata     <= '0;
      ccc_pll_arst_n <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_write  <= req_write;
            cap_relock <= req_relock;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            cnt        <= '0;
            state      <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!ccc_busy) begin
            ccc_psel   <= 1'b1;
            ccc_pwrite <= cap_write;
            ccc_paddr  <= cap_addr;
            ccc_pwdata <= cap_wdata;
            cnt        <= '0;
            state      <= SETUP;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SETUP: begin
          ccc_penable <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          ccc_psel    <= 1'b0;
          ccc_penable <= 1'b0;
          ccc_pwrite  <= 1'b0;
          ccc_paddr   <= '0;
          ccc_pwdata  <= '0;
          if (!cap_write) rsp_rdata <= ccc_prdata;
          if (cap_write && cap_relock) begin
            ccc_pll_arst_n <= 1'b0;
            cnt            <= '0;
            state          <= ARST;
          end else begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        ARST: begin
          if (cnt == CW'(ARST_CYCLES - 1)) begin
            ccc_pll_arst_n <= 1'b1;
            cnt            <= '0;
            state          <= WAIT_LOCK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_LOCK: begin
          // Timeout keeps counting across lock drops; only the stable count restarts.
          if (locked) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccc_reconfig_ctrl.sv
// Directed bench for ccc_reconfig_ctrl with short lock/timeout parameters.
module tb_ccc_reconfig_ctrl;

  logic       PCLK = 1'b0;
  logic       PRESET_N;
  logic       req_valid, req_ready, req_write, req_relock;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       ccc_psel, ccc_penable, ccc_pwrite;
  logic [5:0] ccc_paddr;
  logic [7:0] ccc_pwdata, ccc_prdata;
  logic       ccc_busy, ccc_lock, ccc_pll_arst_n, locked;

  int errors = 0;
  int checks = 0;

  ccc_reconfig_ctrl #(
    .ARST_CYCLES(16),
    .LOCK_STABLE_CYCLES(8),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .PCLK(PCLK), .PRESET_N(PRESET_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_relock(req_relock), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ccc_psel(ccc_psel), .ccc_penable(ccc_penable), .ccc_pwrite(ccc_pwrite),
    .ccc_paddr(ccc_paddr), .ccc_pwdata(ccc_pwdata), .ccc_prdata(ccc_prdata),
    .ccc_busy(ccc_busy), .ccc_lock(ccc_lock), .ccc_pll_arst_n(ccc_pll_arst_n),
    .locked(locked)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Non-relock transaction; n is the negedge index (1 = first after handshake) of rsp_valid.
  task automatic simple_txn(input logic wr, input logic [5:0] a, input logic [7:0] d,
                            output int n, output logic [7:0] rd, output logic er,
                            output logic [2:0] ctl2, output logic [2:0] ctl3,
                            output logic [13:0] ad2, output logic [13:0] ad3,
                            output logic psel_seen);
    n = 0; rd = '0; er = 1'b0; ctl2 = '0; ctl3 = '0; ad2 = '0; ad3 = '0; psel_seen = 1'b0;
    req_valid = 1'b1; req_write = wr; req_relock = 1'b0; req_addr = a; req_wdata = d;
    for (int i = 1; i <= 300; i++) begin
      @(negedge PCLK);
      req_valid = 1'b0;
      if (ccc_psel) psel_seen = 1'b1;
      if (i == 2) begin ctl2 = {ccc_psel, ccc_penable, ccc_pwrite}; ad2 = {ccc_paddr, ccc_pwdata}; end
      if (i == 3) begin ctl3 = {ccc_psel, ccc_penable, ccc_pwrite}; ad3 = {ccc_paddr, ccc_pwdata}; end
      if (rsp_valid) begin n = i; rd = rsp_rdata; er = rsp_err; break; end
    end
  endtask

  // Relock write; r counts negedges from PLL-reset release, lock_at < 0 means lock never returns.
  task automatic relock_txn(input logic [5:0] a, input logic [7:0] d, input int lock_at,
                            input logic glitch, output int arst_low, output int r_rsp,
                            output logic er, output logic lk);
    int r;
    r = 0; arst_low = 0; r_rsp = -1; er = 1'b0; lk = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_relock = 1'b1; req_addr = a; req_wdata = d;
    for (int i = 1; i <= 400; i++) begin
      @(negedge PCLK);
      req_valid = 1'b0;
      if (rsp_valid) begin r_rsp = r; er = rsp_err; lk = locked; break; end
      if (!ccc_pll_arst_n) begin
        arst_low++;
        ccc_lock = 1'b0;
      end else if (arst_low > 0) begin
        if (r == lock_at) ccc_lock = 1'b1;
        if (glitch && r == lock_at + 7) ccc_lock = 1'b0;
        if (glitch && r == lock_at + 8) ccc_lock = 1'b1;
        r++;
      end
    end
  endtask

  initial begin
    int n, arst_low, r_rsp, cnt;
    logic [7:0] rd;
    logic er, lk, ps;
    logic [2:0] c2, c3;
    logic [13:0] a2, a3;

    PRESET_N = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_relock = 1'b0;
    req_addr = '0; req_wdata = '0; ccc_prdata = '0; ccc_busy = 1'b0; ccc_lock = 1'b1;
    repeat (3) @(negedge PCLK);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata_err", {rsp_rdata, rsp_err}, 0);
    chk("rst_apb", {ccc_psel, ccc_penable, ccc_pwrite, ccc_paddr, ccc_pwdata}, 0);
    chk("rst_arst_n", ccc_pll_arst_n, 1);
    chk("rst_locked", locked, 0);
    PRESET_N = 1'b1;
    @(negedge PCLK);
    chk("lock_not_yet", locked, 0);
    repeat (12) @(negedge PCLK);
    chk("lock_qualified", locked, 1);

    // Read 0x15
    ccc_prdata = 8'hA7;
    chk("rd_ready", req_ready, 1);
    simple_txn(1'b0, 6'h15, 8'h00, n, rd, er, c2, c3, a2, a3, ps);
    chk("rd_latency", n, 4);
    chk("rd_setup_ctl", c2, 3'b100);
    chk("rd_access_ctl", c3, 3'b110);
    chk("rd_setup_addr", a2, {6'h15, 8'h00});
    chk("rd_access_addr", a3, {6'h15, 8'h00});
    chk("rd_data", rd, 8'hA7);
    chk("rd_err", er, 0);
    chk("rd_apb_idle", {ccc_psel, ccc_penable, ccc_paddr}, 0);
    @(negedge PCLK);
    chk("rd_pulse_one", rsp_valid, 0);
    chk("rd_back_idle", req_ready, 1);

    // Write without relock
    simple_txn(1'b1, 6'h07, 8'h3A, n, rd, er, c2, c3, a2, a3, ps);
    chk("wr_latency", n, 4);
    chk("wr_setup_ctl", c2, 3'b101);
    chk("wr_access_ctl", c3, 3'b111);
    chk("wr_access_addr", a3, {6'h07, 8'h3A});
    chk("wr_rdata_zero", rd, 0);
    chk("wr_err", er, 0);
    chk("wr_no_arst", ccc_pll_arst_n, 1);
    @(negedge PCLK);

    // Busy held high: timeout after 100 clocks, no APB access
    ccc_busy = 1'b1;
    simple_txn(1'b0, 6'h01, 8'h00, n, rd, er, c2, c3, a2, a3, ps);
    chk("busy_tmo_latency", n, 101);
    chk("busy_tmo_err", er, 1);
    chk("busy_no_psel", ps, 0);
    ccc_busy = 1'b0;
    @(negedge PCLK);

    // Relock write, lock returns 40 clocks after release
    relock_txn(6'h03, 8'h2C, 40, 1'b0, arst_low, r_rsp, er, lk);
    chk("relock_arst_width", arst_low, 16);
    chk("relock_rsp_time", r_rsp, 51);
    chk("relock_err", er, 0);
    chk("relock_locked", lk, 1);
    @(negedge PCLK);

    // Relock with a one-clock lock glitch at stable count 5
    relock_txn(6'h03, 8'h2C, 40, 1'b1, arst_low, r_rsp, er, lk);
    chk("glitch_arst_width", arst_low, 16);
    chk("glitch_rsp_time", r_rsp, 59);
    chk("glitch_err", er, 0);
    chk("glitch_locked", lk, 1);
    @(negedge PCLK);

    // Relock with lock never returning
    relock_txn(6'h03, 8'h2C, -1, 1'b0, arst_low, r_rsp, er, lk);
    chk("nolock_rsp_time", r_rsp, 100);
    chk("nolock_err", er, 1);
    chk("nolock_locked", lk, 0);
    ccc_lock = 1'b1;
    @(negedge PCLK);

    // Reset asserted during ARST
    req_valid = 1'b1; req_write = 1'b1; req_relock = 1'b1; req_addr = 6'h03; req_wdata = 8'h2C;
    @(negedge PCLK);
    req_valid = 1'b0;
    repeat (8) @(negedge PCLK);
    chk("mid_in_arst", ccc_pll_arst_n, 0);
    PRESET_N = 1'b0;
    #1;
    chk("mid_arst_released", ccc_pll_arst_n, 1);
    chk("mid_no_rsp", rsp_valid, 0);
    chk("mid_ready", req_ready, 1);
    chk("mid_apb", {ccc_psel, ccc_penable}, 0);
    @(negedge PCLK);
    PRESET_N = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge PCLK);
      if (rsp_valid) cnt++;
    end
    chk("mid_no_late_rsp", cnt, 0);
    chk("mid_ready_after", req_ready, 1);
    ccc_prdata = 8'h5C;
    simple_txn(1'b0, 6'h2A, 8'h00, n, rd, er, c2, c3, a2, a3, ps);
    chk("post_rd_latency", n, 4);
    chk("post_rd_data", rd, 8'h5C);
    chk("post_rd_err", er, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
